// File: rtl/arith_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
// Holds the FSM state encoding and the digit-counter width calculation.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-digit configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n, input int d);
    int w;
    w = $clog2(n / d);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational D-bit ripple-carry adder for one digit.
// Also exposes the carry into its top bit for signed-overflow detection.
module digit_adder #(
  parameter int D = 2
) (
  input  logic [D-1:0] a_d,
  input  logic [D-1:0] b_d,
  input  logic         c_in,
  output logic [D-1:0] s_d,
  output logic         c_out,
  output logic         c_msb_in
);

  logic [D:0] c_s;

  // Ripple chain of full adders.
  always_comb begin
    c_s    = '0;
    s_d    = '0;
    c_s[0] = c_in;
    for (int i = 0; i < D; i++) begin
      s_d[i]   = a_d[i] ^ b_d[i] ^ c_s[i];
      c_s[i+1] = (a_d[i] & b_d[i]) | (a_d[i] & c_s[i]) | (b_d[i] & c_s[i]);
    end
  end

  assign c_out    = c_s[D];
  assign c_msb_in = c_s[D-1];

endmodule

// File: rtl/serial_adder_subtractor.sv
// Digit-serial N-bit adder/subtractor, D bits per clock, LSB digit first.
// Subtraction is a + ~b + 1: B is inverted at accept and the carry seeded with sub.
module serial_adder_subtractor
  import arith_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         overflow,
  output logic         zero
);

  localparam int NDIG = N / D;
  localparam int CW   = cnt_width(N, D);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, b_q, s_q;
  logic [N-1:0]  s_next_s;
  logic [CW-1:0] cnt_q;
  logic          carry_q;
  logic          c_out_q, ovf_q, zero_q;
  logic          in_ready_q, out_valid_q;
  logic          in_ready_d, out_valid_d;
  logic [D-1:0]  a_dig_s, b_dig_s, s_dig_s;
  logic          c_dig_s, c_msb_s;
  logic          last_s, accept_s;

  assign last_s   = (cnt_q == LAST);
  assign accept_s = in_valid & in_ready_q;
  assign a_dig_s  = a_q[cnt_q*D +: D];
  assign b_dig_s  = b_q[cnt_q*D +: D];

  digit_adder #(.D(D)) u_digit (
    .a_d      (a_dig_s),
    .b_d      (b_dig_s),
    .c_in     (carry_q),
    .s_d      (s_dig_s),
    .c_out    (c_dig_s),
    .c_msb_in (c_msb_s)
  );

  // Result with the current digit merged in; on the last digit this is the full sum.
  always_comb begin
    s_next_s = s_q;
    s_next_s[cnt_q*D +: D] = s_dig_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state so they are registered.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // Handshake output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand latch, digit iteration and flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            a_q     <= a;
            b_q     <= b ^ {N{sub}};
            carry_q <= sub;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          s_q     <= s_next_s;
          carry_q <= c_dig_s;
          cnt_q   <= cnt_q + CW'(1);
          if (last_s) begin
            c_out_q <= c_dig_s;
            ovf_q   <= c_msb_s ^ c_dig_s;
            zero_q  <= (s_next_s == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Self-checking bench: four instances (D = 1, 2, 4, 8; N = 8) driven with directed
// and random operations and compared against an integer-arithmetic reference model.
module tb_serial_adder_subtractor;

  localparam int N  = 8;
  localparam int NI = 4;

  logic         clk;
  logic         rst_n;
  logic         iv   [NI];
  logic         ir   [NI];
  logic         sb   [NI];
  logic         ovl  [NI];
  logic         ordy [NI];
  logic         co   [NI];
  logic         of   [NI];
  logic         zr   [NI];
  logic [N-1:0] av   [NI];
  logic [N-1:0] bv   [NI];
  logic [N-1:0] sv   [NI];

  int n_cmp;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serial_adder_subtractor #(.N(N), .D(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .sub       (sb[g]),
      .a         (av[g]),
      .b         (bv[g]),
      .out_valid (ovl[g]),
      .out_ready (ordy[g]),
      .s         (sv[g]),
      .c_out     (co[g]),
      .overflow  (of[g]),
      .zero      (zr[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic. Returns {zero, ovf, c_out, s}.
  function automatic logic [10:0] ref_model(input logic [7:0] x, input logic [7:0] y, input logic sbit);
    int ux, uy, sx, sy, ur, sr;
    logic [7:0] r;
    logic c, v, z;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    if (sbit) begin
      ur = ux - uy;
      sr = sx - sy;
      c  = (ux >= uy);
    end else begin
      ur = ux + uy;
      sr = sx + sy;
      c  = (ur > 255);
    end
    r = ur[7:0];
    v = (sr > 127) || (sr < -128);
    z = (r == 8'h00);
    return {z, v, c, r};
  endfunction

  // One full transaction on instance k, with 'hold' cycles of back-pressure in DONE.
  task automatic run_op(input int k, input logic [7:0] x, input logic [7:0] y,
                        input logic sbit, input int hold, input string tag);
    logic [10:0] exp;
    logic [7:0]  s_seen;
    int          lat;
    int          w;
    exp = ref_model(x, y, sbit);
    w = 0;
    while (!ir[k] && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq({tag, "/in_ready_idle"}, 32'(ir[k]), 32'd1);
    iv[k] = 1'b1;
    av[k] = x;
    bv[k] = y;
    sb[k] = sbit;
    @(posedge clk); #1;
    // Scramble inputs after the accept edge: the result must come from the latched operands.
    iv[k] = 1'b0;
    av[k] = 8'($urandom);
    bv[k] = 8'($urandom);
    sb[k] = 1'($urandom);
    // Latency counts rising edges from the accept edge through the edge raising out_valid.
    lat = 1;
    while (!ovl[k] && lat < 40) begin
      check_eq({tag, "/in_ready_busy"}, 32'(ir[k]), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "/latency"}, 32'(lat), 32'(N / (1 << k) + 1));
    check_eq({tag, "/s"}, 32'(sv[k]), 32'(exp[7:0]));
    check_eq({tag, "/c_out"}, 32'(co[k]), 32'(exp[8]));
    check_eq({tag, "/overflow"}, 32'(of[k]), 32'(exp[9]));
    check_eq({tag, "/zero"}, 32'(zr[k]), 32'(exp[10]));
    s_seen = sv[k];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq({tag, "/hold_s"}, 32'(sv[k]), 32'(s_seen));
      check_eq({tag, "/hold_valid"}, 32'(ovl[k]), 32'd1);
      check_eq({tag, "/hold_ready"}, 32'(ir[k]), 32'd0);
    end
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    check_eq({tag, "/valid_drop"}, 32'(ovl[k]), 32'd0);
    check_eq({tag, "/ready_back"}, 32'(ir[k]), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int k = 0; k < NI; k++) begin
      iv[k]   = 1'b0;
      sb[k]   = 1'b0;
      ordy[k] = 1'b0;
      av[k]   = 8'h00;
      bv[k]   = 8'h00;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check_eq("rst/in_ready", 32'(ir[k]), 32'd1);
      check_eq("rst/out_valid", 32'(ovl[k]), 32'd0);
      check_eq("rst/s", 32'(sv[k]), 32'd0);
      check_eq("rst/c_out", 32'(co[k]), 32'd0);
      check_eq("rst/overflow", 32'(of[k]), 32'd0);
      check_eq("rst/zero", 32'(zr[k]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases on the D=2 instance.
    run_op(1, 8'h3C, 8'h05, 1'b0, 0, "add_3c_05");
    run_op(1, 8'h05, 8'h05, 1'b1, 0, "sub_05_05");
    run_op(1, 8'h7F, 8'h01, 1'b0, 0, "add_7f_01");
    run_op(1, 8'h00, 8'h01, 1'b1, 0, "sub_00_01");
    run_op(1, 8'h80, 8'h01, 1'b1, 0, "sub_80_01");
    run_op(1, 8'h12, 8'h34, 1'b0, 10, "backpressure");

    // Reset during the second RUN cycle.
    iv[1] = 1'b1;
    av[1] = 8'h55;
    bv[1] = 8'h66;
    sb[1] = 1'b0;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst/in_ready", 32'(ir[1]), 32'd1);
    check_eq("midrst/out_valid", 32'(ovl[1]), 32'd0);
    check_eq("midrst/s", 32'(sv[1]), 32'd0);
    check_eq("midrst/c_out", 32'(co[1]), 32'd0);
    check_eq("midrst/overflow", 32'(of[1]), 32'd0);
    check_eq("midrst/zero", 32'(zr[1]), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("midrst/no_valid", 32'(ovl[1]), 32'd0);
    end
    run_op(1, 8'hFF, 8'h01, 1'b0, 0, "add_ff_01");

    // Random sweep over every digit width.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 1000; i++) begin
        run_op(k, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
